gate_sweep_ctrl: RTL
====================

// Module: gate_sweep_ctrl
// PURPOSE
//  Sequencer for the 2-input gate test datapath.
//  - Drives every input combination (0..2^N_IN-1) in ascending order onto a shared gate input bus.
//  - Waits a settle interval per vector, then compares the reference (expression) output with the
//    gate-level output.
//  - Accumulates a mismatch count and records the first failing vector.
//  - Replaces hand-written #delay stimulus blocks with a clocked, self-checking sweep.
// PARAMETERS
//  N_IN    2  width of gate input vector; sweep length = 2^N_IN vectors
//  SETTLE  1  cycles held per vector before sampling; legal range 1..15
// PORTS
//  clk            in   1        system clock, rising edge
//  rst_n          in   1        asynchronous reset, active low
//  start          in   1        sweep request, sampled on rising clk
//  s_ref          in   1        reference output (expression model) for current vector
//  s_dut          in   1        gate-level output under test for current vector
//  vec_out        out  N_IN     gate input vector; bit N_IN-1 = a (MSB), bit 0 = b
//  busy           out  1        sweep in progress
//  sample_stb     out  1        1-cycle strobe in the cycle the compare is taken
//  done           out  1        sweep complete; held until next accepted start
//  pass           out  1        valid when done=1: 1 iff err_count==0
//  err_count      out  N_IN+1   number of mismatching vectors, 0..2^N_IN
//  first_err_vec  out  N_IN     vector of first mismatch; 0 when err_count==0
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, regardless of clk):
//  - state=IDLE; all outputs 0; settle counter cleared.
//  - Takes effect mid-sweep with no completion.
//  - After rst_n rises, the block waits in IDLE for a new start.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE: busy=0, done=0. start=1 -> clear err_count/first_err_vec, vec_out<=0,
//    settle_cnt<=SETTLE-1, go SETTLE.
//  - SETTLE: busy=1; vec_out stable. settle_cnt==0 -> SAMPLE, else decrement.
//  - SAMPLE (1 cycle): busy=1, sample_stb=1; mismatch = (s_ref != s_dut).
//    On mismatch: err_count+1; if err_count was 0, first_err_vec<=vec_out.
//    vec_out==2^N_IN-1 -> DONE. Otherwise vec_out+1, settle_cnt<=SETTLE-1, -> SETTLE.
//  - DONE: busy=0, done=1, pass=(err_count==0). vec_out holds last vector.
//    start=1 -> same action as IDLE start (restart); done drops the next cycle.
//  Handshake and counter rules:
//  - start is ignored while busy=1; no queuing.
//  - start is level-sampled; holding it high in DONE causes back-to-back sweeps.
//  - vec_out never wraps during a sweep; terminal vector 2^N_IN-1 ends the sweep.
//  - err_count cannot overflow: width N_IN+1 holds the maximum of 2^N_IN.
//  Latency:
//  - Per vector: SETTLE+1 cycles.
//  - done rises 2^N_IN*(SETTLE+1)+1 clk edges after the edge that samples start.
//    Default parameters: 9 edges.
//  - The compare uses s_ref/s_dut as seen at the SAMPLE edge. DUT inputs are combinational from vec_out.
// TESTING
//  1 Assert rst_n=0 at t=0 with no clk -> all outputs 0 immediately.
//    Release, no start -> stays IDLE, busy=0.
//  2 Connect correct XNOR f5a/f5b pair (defaults), pulse start -> vec_out steps 0,1,2,3;
//    4 sample_stb pulses; done at edge 9; pass=1; err_count=0; first_err_vec=0.
//  3 s_dut tied 0, s_ref=XNOR -> mismatches at vectors 0 and 3:
//    err_count=2, first_err_vec=2'b00, pass=0.
//  4 Hold start high through the whole sweep (start while busy) -> sweep unaffected.
//    In DONE, start=1 -> counters cleared, vec_out=0, busy=1, done=0 next cycle.
//  5 Drop rst_n asynchronously while vec_out=2 in SETTLE -> immediate IDLE, all outputs 0.
//    After release, a fresh start completes normally.
//  6 SETTLE=3, N_IN=3, s_dut=~s_ref -> 8 vectors, done at edge 33,
//    err_count=8, first_err_vec=3'b000.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: clocked exhaustive sweep of a gate input vector with a
// self-checking compare of reference vs. gate-level output per vector.
module gate_sweep_ctrl #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            s_ref,
   input  logic            s_dut,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            sample_stb,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_err_vec
);

   localparam logic [N_IN-1:0] LastVec    = '1;
   localparam logic [3:0]      SettleInit = 4'(SETTLE - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_t;

   state_t     state;
   logic [3:0] settle_cnt;
   logic       launch;

   // A new sweep is accepted from IDLE, or from DONE once done is visible
   // (busy still high in the first DONE cycle, so start is ignored there).
   always_comb begin
      launch = start && ((state == StIdle) || ((state == StDone) && !busy));
   end

   // Sweep sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= StIdle;
         settle_cnt    <= '0;
         vec_out       <= '0;
         busy          <= 1'b0;
         sample_stb    <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_vec <= '0;
      end else begin
         sample_stb <= 1'b0;
         if (launch) begin
            state         <= StSettle;
            settle_cnt    <= SettleInit;
            vec_out       <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
         end else begin
            unique case (state)
               StIdle: begin
               end
               StSettle: begin
                  if (settle_cnt == 4'd0) begin
                     state      <= StSample;
                     sample_stb <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - 4'd1;
                  end
               end
               StSample: begin
                  if (s_ref != s_dut) begin
                     err_count <= err_count + 1'b1;
                     if (err_count == '0) begin
                        first_err_vec <= vec_out;
                     end
                  end
                  if (vec_out == LastVec) begin
                     state <= StDone;
                  end else begin
                     vec_out    <= vec_out + 1'b1;
                     settle_cnt <= SettleInit;
                     state      <= StSettle;
                  end
               end
               StDone: begin
                  // First DONE cycle publishes the result; busy drops with it.
                  if (busy) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                     pass <= (err_count == '0);
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
